zyy_game_timer: RTL and testbench
=================================

// Module: zyy_game_timer
// PURPOSE
//  Elapsed-game-time stopwatch: runs from game start until game over; feeds BCD mm:ss to the 7-seg scanner.
//  Sits upstream of the 7-seg display driver, on the 100 MHz system clock.
//  Takes the same start/over signals as the VGA game core.
//  Moves all time-keeping out of the scanner; the scanner only multiplexes digits.
// PARAMETERS
//  CLK_HZ   100_000_000  system clock frequency in Hz
//  TICK_HZ  1            counting rate (100 when ZYY_TIMER_CSEC_EN); DIV = CLK_HZ/TICK_HZ, must be >= 2
// PORTS
//  clk        in   1  system clock, 100 MHz
//  rst        in   1  synchronous reset, active-high
//  start      in   1  game-start switch level, asynchronous
//  over       in   1  game-over level from the VGA game core (25 MHz domain)
//  running    out  1  1 while in RUN
//  ovf        out  1  sticky: 99:59 reached
//  upd        out  1  1-clk pulse on every digit update
//  min_tens   out  4  BCD 0-9
//  min_ones   out  4  BCD 0-9
//  sec_tens   out  4  BCD 0-5
//  sec_ones   out  4  BCD 0-9
//  cs_tens    out  4  BCD 0-9, centiseconds; tied 0 without macro
//  cs_ones    out  4  BCD 0-9; tied 0 without macro
// BEHAVIOUR
//  - Reset: state IDLE; all digits 0; running=0; ovf=0; upd=0; prescaler 0; sync flops 0.
//  - start and over each pass a 2-FF synchroniser (start_s, over_s). start_rise = start_s & ~start_q.
//  - Prescaler counts 0..DIV-1 only in RUN. tick is asserted when the count = DIV-1; the count then wraps to 0.
//  - A tick increments the digit chain (cs -> sec_ones -> sec_tens(mod 6) -> min_ones -> min_tens) by ripple carry, in one clk.
//  - upd pulses in the cycle after any digit change, including a clear.
//  - FSM, priority per cycle: ~start_s > over_s > tick.
//    IDLE: start_rise & ~over_s -> RUN.
//          On entry to RUN, digits, prescaler and ovf are cleared.
//    RUN:  ~start_s -> IDLE, digits cleared.
//          over_s -> STOP, digits frozen.
//          tick at max (99:59, or 99:59.99 with macro) -> STOP with ovf=1; digits stay at max, no wrap.
//    STOP: ~start_s -> IDLE, digits cleared; otherwise hold. A new game needs start low then high.
//  - Latency: start 0->1 at the pin gives running=1 on the 3rd rising edge.
//    over 0->1 gives a freeze within 3 edges. A tick in the same cycle as over_s is discarded.
//  - over already high at start_rise: stay in IDLE.
//  - rst asserted in any state: back to reset values on the next edge.
// CONFIGURATION
//  ZYY_TIMER_CSEC_EN defined:
//    TICK_HZ defaults to 100. cs_tens/cs_ones count 00-99 and carry into sec_ones.
//  ZYY_TIMER_CSEC_EN undefined:
//    TICK_HZ defaults to 1. cs_* are constant 0 and the cs chain is not synthesised.
// STRUCTURE
//  zyy_timer_pkg:
//    state encoding IDLE/RUN/STOP
//    digit limits (DIG_MAX_9=4'd9, DIG_MAX_5=4'd5)
//    DIV computation function
//  Sub-module zyy_bcd_digit #(MAX):
//    ports clk, rst, clr, inc -> q[3:0], carry (= inc & q==MAX)
//    4 instances, or 6 with the macro
//  Top level: synchronisers, prescaler, FSM, saturation detect, upd register.
// TESTING (CLK_HZ=1000, TICK_HZ=1 -> DIV=1000 unless noted)
//  1 rst=1 for 2 clk, then start=0 -> all digits 0, running=0, ovf=0, upd=0.
//  2 start 0->1 -> running=1 at edge 3; after 1000 clk sec_ones=1 and upd pulses once;
//    after 60_000 clk reads 01:00.
//  3 Running at 00:07, over=1 -> digits frozen at 00:07, running=0 within 3 clk;
//    over=0 -> still frozen; start=0 -> 00:00 and IDLE.
//  4 Preload via force to 99:58, then 2000 clk -> reads 99:59, ovf=1, running=0; no wrap to 00:00.
//  5 over=1 held, start 0->1 -> stays in IDLE, running=0, digits 0.
//  6 ZYY_TIMER_CSEC_EN, TICK_HZ=100, DIV=10: after 1000 clk reads 00:01.00 and cs digits are seen passing 99->00.

Source files
------------

// File: rtl/zyy_timer_pkg.sv
// ---------------------------------------------------------------------------
// zyy_timer_pkg
// Shared definitions for the game stopwatch (zyy_game_timer).
//   - state_e          : controller states (idle / running / stopped)
//   - DIG_MAX_9/5      : wrap limits for the BCD digit counters
//   - TICK_HZ_DEFAULT  : counting rate, 100 Hz when ZYY_TIMER_CSEC_EN is
//                        defined (centisecond digits), otherwise 1 Hz
//   - calc_div()       : clock cycles per counting tick
// ---------------------------------------------------------------------------
package zyy_timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } state_e;

    localparam logic [3:0] DIG_MAX_9 = 4'd9;
    localparam logic [3:0] DIG_MAX_5 = 4'd5;

`ifdef ZYY_TIMER_CSEC_EN
    localparam int unsigned TICK_HZ_DEFAULT = 100;
`else
    localparam int unsigned TICK_HZ_DEFAULT = 1;
`endif

    // Cycles per tick; the prescaler assumes a result of at least 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/zyy_bcd_digit.sv
// ---------------------------------------------------------------------------
// zyy_bcd_digit
// One BCD digit of the stopwatch chain: counts 0..MAX and wraps to 0.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   clr    in   synchronous clear to 0 (wins over inc)
//   inc    in   advance by one this cycle
//   q      out  current digit value
//   carry  out  inc & (q == MAX): the next digit must advance too
// ---------------------------------------------------------------------------
module zyy_bcd_digit
    import zyy_timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIG_MAX_9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_d;
    logic [3:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/zyy_game_timer.sv
// ---------------------------------------------------------------------------
// zyy_game_timer
// Elapsed-game-time stopwatch. Runs from game start until game over and
// presents BCD mm:ss (plus centiseconds when ZYY_TIMER_CSEC_EN is defined)
// to the 7-seg scanner, which only multiplexes digits.
//
// Configuration macro: ZYY_TIMER_CSEC_EN
//   defined   : TICK_HZ defaults to 100, cs_tens/cs_ones count 00-99 and
//               carry into sec_ones; saturation point is 99:59.99
//   undefined : TICK_HZ defaults to 1, cs_* are constant 0, no cs counters
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   start      in   game-start switch level (asynchronous)
//   over       in   game-over level from the game core (other clock domain)
//   running    out  1 while counting
//   ovf        out  sticky: saturated at the maximum time
//   upd        out  1-clk pulse in the cycle after any digit change/clear
//   min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones  out  BCD digits
// ---------------------------------------------------------------------------
module zyy_game_timer
    import zyy_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       over,
    output logic       running,
    output logic       ovf,
    output logic       upd,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] cs_ones
);

    localparam int unsigned   DIV        = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    // Synchronisers; start_q is start_s delayed once for edge detection.
    logic start_meta_d, start_meta_q;
    logic start_s_d, start_s_q;
    logic start_d, start_q;
    logic over_meta_d, over_meta_q;
    logic over_s_d, over_s_q;

    state_e        state_d, state_q;
    logic [PW-1:0] presc_d, presc_q;
    logic          ovf_d, ovf_q;
    logic          upd_d, upd_q;
    logic          running_d, running_q;

    logic start_rise;
    logic tick;
    logic at_max;
    logic digit_clr;
    logic tick_inc;

    // Digit chain carries.
    logic sec_inc;
    logic c_sec_ones;
    logic c_sec_tens;
    logic c_min_ones;
    logic unused_c_min_tens;

    // -----------------------------------------------------------------------
    // Control: synchronisers, prescaler and state machine next-state
    // -----------------------------------------------------------------------
    always_comb begin
        start_meta_d = start;
        start_s_d    = start_meta_q;
        start_d      = start_s_q;
        over_meta_d  = over;
        over_s_d     = over_meta_q;

        start_rise = start_s_q & ~start_q;
        tick       = (state_q == StRun) && (presc_q == PRESC_LAST);

        state_d   = state_q;
        presc_d   = presc_q;
        ovf_d     = ovf_q;
        digit_clr = 1'b0;
        tick_inc  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A game already over at start does not begin counting.
                if (start_rise && !over_s_q) begin
                    state_d   = StRun;
                    presc_d   = '0;
                    ovf_d     = 1'b0;
                    digit_clr = 1'b1;
                end
            end
            StRun: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                // Priority: start released > game over > tick.
                if (!start_s_q) begin
                    state_d   = StIdle;
                    digit_clr = 1'b1;
                end else if (over_s_q) begin
                    state_d = StStop;
                end else if (tick) begin
                    if (at_max) begin
                        // Saturate rather than wrap to 00:00.
                        state_d = StStop;
                        ovf_d   = 1'b1;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            StStop: begin
                if (!start_s_q) begin
                    state_d   = StIdle;
                    digit_clr = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                digit_clr = 1'b1;
            end
        endcase

        running_d = (state_d == StRun);
        upd_d     = digit_clr | tick_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_meta_q <= 1'b0;
            start_s_q    <= 1'b0;
            start_q      <= 1'b0;
            over_meta_q  <= 1'b0;
            over_s_q     <= 1'b0;
            state_q      <= StIdle;
            presc_q      <= '0;
            ovf_q        <= 1'b0;
            upd_q        <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            start_meta_q <= start_meta_d;
            start_s_q    <= start_s_d;
            start_q      <= start_d;
            over_meta_q  <= over_meta_d;
            over_s_q     <= over_s_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            ovf_q        <= ovf_d;
            upd_q        <= upd_d;
            running_q    <= running_d;
        end
    end

    assign running = running_q;
    assign ovf     = ovf_q;
    assign upd     = upd_q;

    // -----------------------------------------------------------------------
    // Digit chain: ripple carry, all digits update on the same edge
    // -----------------------------------------------------------------------
`ifdef ZYY_TIMER_CSEC_EN
    logic c_cs_ones;
    logic c_cs_tens;

    zyy_bcd_digit #(.MAX(DIG_MAX_9)) u_cs_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (digit_clr),
        .inc   (tick_inc),
        .q     (cs_ones),
        .carry (c_cs_ones)
    );

    zyy_bcd_digit #(.MAX(DIG_MAX_9)) u_cs_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (digit_clr),
        .inc   (c_cs_ones),
        .q     (cs_tens),
        .carry (c_cs_tens)
    );

    assign sec_inc = c_cs_tens;
    assign at_max  = (min_tens == DIG_MAX_9) && (min_ones == DIG_MAX_9) &&
                     (sec_tens == DIG_MAX_5) && (sec_ones == DIG_MAX_9) &&
                     (cs_tens == DIG_MAX_9) && (cs_ones == DIG_MAX_9);
`else
    assign sec_inc = tick_inc;
    assign cs_tens = 4'd0;
    assign cs_ones = 4'd0;
    assign at_max  = (min_tens == DIG_MAX_9) && (min_ones == DIG_MAX_9) &&
                     (sec_tens == DIG_MAX_5) && (sec_ones == DIG_MAX_9);
`endif

    zyy_bcd_digit #(.MAX(DIG_MAX_9)) u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (digit_clr),
        .inc   (sec_inc),
        .q     (sec_ones),
        .carry (c_sec_ones)
    );

    zyy_bcd_digit #(.MAX(DIG_MAX_5)) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (digit_clr),
        .inc   (c_sec_ones),
        .q     (sec_tens),
        .carry (c_sec_tens)
    );

    zyy_bcd_digit #(.MAX(DIG_MAX_9)) u_min_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (digit_clr),
        .inc   (c_sec_tens),
        .q     (min_ones),
        .carry (c_min_ones)
    );

    // Top carry never fires: saturation stops the chain before it would.
    zyy_bcd_digit #(.MAX(DIG_MAX_9)) u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (digit_clr),
        .inc   (c_min_ones),
        .q     (min_tens),
        .carry (unused_c_min_tens)
    );

endmodule

// File: tb/tb_zyy_game_timer.sv
// ---------------------------------------------------------------------------
// tb_zyy_game_timer
// Bench for zyy_game_timer (default build). Two instances share the clock:
//   dut  : CLK_HZ=1000, TICK_HZ=1  -> 1000 cycles per second
//   fdut : CLK_HZ=4,    TICK_HZ=2  -> 2 cycles per second, reaches 99:59 fast
// Expected digits come from elapsed time: a game entered at edge e0 shows
// floor((edge - e0) / DIV) seconds, capped at 99:59.
// ---------------------------------------------------------------------------
module tb_zyy_game_timer;

    localparam int unsigned DIV       = 1000;
    localparam int unsigned FDIV      = 2;
    localparam int unsigned MAX_TICKS = 5999;

    logic clk = 1'b0;
    logic rst;
    logic start, over;
    logic running, ovf, upd;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;

    logic f_start, f_over;
    logic f_running, f_ovf, f_upd;
    logic [3:0] f_min_tens, f_min_ones, f_sec_tens, f_sec_ones, f_cs_tens, f_cs_ones;

    logic [15:0] dig, f_dig;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    assign dig   = {min_tens, min_ones, sec_tens, sec_ones};
    assign f_dig = {f_min_tens, f_min_ones, f_sec_tens, f_sec_ones};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zyy_game_timer #(.CLK_HZ(1000), .TICK_HZ(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .over     (over),
        .running  (running),
        .ovf      (ovf),
        .upd      (upd),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .cs_tens  (cs_tens),
        .cs_ones  (cs_ones)
    );

    zyy_game_timer #(.CLK_HZ(4), .TICK_HZ(2)) fdut (
        .clk      (clk),
        .rst      (rst),
        .start    (f_start),
        .over     (f_over),
        .running  (f_running),
        .ovf      (f_ovf),
        .upd      (f_upd),
        .min_tens (f_min_tens),
        .min_ones (f_min_ones),
        .sec_tens (f_sec_tens),
        .sec_ones (f_sec_ones),
        .cs_tens  (f_cs_tens),
        .cs_ones  (f_cs_ones)
    );

    // Seconds count -> mm:ss BCD, saturating at 99:59.
    function automatic logic [15:0] model_digits(input int unsigned ticks);
        int unsigned t;
        t = (ticks > MAX_TICKS) ? MAX_TICKS : ticks;
        return {4'(t / 600), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; over = 1'b0; f_start = 1'b0; f_over = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({running, ovf, upd, dig, cs_tens, cs_ones} !== 27'd0) begin
            errors++;
            $display("FAIL reset_main: got run=%b ovf=%b upd=%b dig=%h cs=%h%h, want all 0",
                     running, ovf, upd, dig, cs_tens, cs_ones);
        end
        checks++;
        if ({f_running, f_ovf, f_upd, f_dig, f_cs_tens, f_cs_ones} !== 27'd0) begin
            errors++;
            $display("FAIL reset_fast: got run=%b ovf=%b upd=%b dig=%h, want all 0",
                     f_running, f_ovf, f_upd, f_dig);
        end
    endtask

    // Start a game and let it run for exactly one minute.
    task automatic test_start();
        int unsigned s1, e0, n, upd_first, upd_all;
        @(negedge clk);
        start = 1'b1;
        s1 = cyc + 1;
        e0 = s1 + 2;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL start_latency_early: running=%b at edge 2, want 0", running);
        end
        @(negedge clk);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: running=%b at edge 3, want 1", running);
        end
        upd_first = 0;
        upd_all   = 0;
        for (int i = 0; i < 60 * DIV; i++) begin
            @(negedge clk);
            n = cyc - e0;
            checks++;
            if (dig !== model_digits(n / DIV)) begin
                errors++;
                $display("FAIL run_digits: n=%0d got %h want %h", n, dig, model_digits(n / DIV));
            end
            if (upd === 1'b1) begin
                upd_all++;
                if (n <= DIV) upd_first++;
            end
        end
        checks++;
        if (upd_first != 1) begin
            errors++;
            $display("FAIL upd_first_second: %0d pulses, want 1", upd_first);
        end
        checks++;
        if (upd_all != 60) begin
            errors++;
            $display("FAIL upd_one_minute: %0d pulses, want 60", upd_all);
        end
        checks++;
        if ({running, dig} !== {1'b1, 16'h0100}) begin
            errors++;
            $display("FAIL one_minute: run=%b dig=%h, want 1 0100", running, dig);
        end
    endtask

    // Run the fast instance into saturation, then restart it.
    task automatic test_overflow();
        int unsigned s1, e0, n;
        logic [16:0] want;
        repeat (5) @(negedge clk);
        f_start = 1'b1;
        s1 = cyc + 1;
        e0 = s1 + 2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2 * (MAX_TICKS + 1) + 20; i++) begin
            @(negedge clk);
            n = cyc - e0;
            // The tick after 99:59 stops the game instead of wrapping.
            want = {model_digits(n / FDIV), (n / FDIV) > MAX_TICKS};
            checks++;
            if ({f_dig, f_ovf} !== want || f_running !== ((n / FDIV) <= MAX_TICKS)) begin
                errors++;
                $display("FAIL overflow_run: n=%0d got dig=%h ovf=%b run=%b want dig=%h ovf=%b",
                         n, f_dig, f_ovf, f_running, want[16:1], want[0]);
            end
        end
        f_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({f_running, f_ovf, f_dig} !== {2'b01, 16'h0000}) begin
            errors++;
            $display("FAIL overflow_sticky: run=%b ovf=%b dig=%h, want 0 1 0000",
                     f_running, f_ovf, f_dig);
        end
        repeat (3) @(negedge clk);
        f_start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({f_running, f_ovf, f_dig} !== {2'b10, 16'h0000}) begin
            errors++;
            $display("FAIL overflow_restart: run=%b ovf=%b dig=%h, want 1 0 0000",
                     f_running, f_ovf, f_dig);
        end
        f_start = 1'b0;
    endtask

    // Game over freezes the digits; offsets 2*DIV / 2*DIV+1 straddle a tick.
    task automatic test_freeze();
        int unsigned s1, f1, run;
        logic [15:0] want;
        for (int it = 0; it < 3; it++) begin
            start = 1'b0;
            over  = 1'b0;
            repeat (5) @(negedge clk);
            start = 1'b1;
            s1 = cyc + 1;
            run = (it == 0) ? 2 * DIV : (it == 1) ? 2 * DIV + 1 : $urandom_range(3 * DIV, DIV);
            repeat (run) @(negedge clk);
            over = 1'b1;
            f1 = cyc + 1;
            want = model_digits((f1 - s1 - 1) / DIV);
            repeat (3) @(negedge clk);
            checks++;
            if ({running, dig} !== {1'b0, want}) begin
                errors++;
                $display("FAIL freeze_%0d: run=%b dig=%h, want 0 %h", it, running, dig, want);
            end
            repeat (DIV + 3) @(negedge clk);
            over = 1'b0;
            repeat (DIV + 3) @(negedge clk);
            checks++;
            if ({running, dig} !== {1'b0, want}) begin
                errors++;
                $display("FAIL freeze_hold_%0d: run=%b dig=%h, want 0 %h", it, running, dig, want);
            end
            start = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if ({running, dig} !== 17'd0) begin
                errors++;
                $display("FAIL freeze_clear_%0d: run=%b dig=%h, want 0 0000", it, running, dig);
            end
        end
    endtask

    // Releasing start mid-run returns to idle with digits cleared.
    task automatic test_abort();
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        repeat ($urandom_range(2 * DIV, DIV + 5)) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL abort_latency: running=%b two edges after release, want 1", running);
        end
        @(negedge clk);
        checks++;
        if ({running, dig} !== 17'd0) begin
            errors++;
            $display("FAIL abort_clear: run=%b dig=%h, want 0 0000", running, dig);
        end
    endtask

    // Game over already asserted at start: the timer must not begin.
    task automatic test_over_held();
        start = 1'b0;
        over  = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({running, dig} !== 17'd0) begin
            errors++;
            $display("FAIL over_held: run=%b dig=%h, want 0 0000", running, dig);
        end
        over = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL over_release_no_rise: running=%b, want 0", running);
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Reset while counting returns everything to reset values.
    task automatic test_rst_midrun();
        int unsigned s1;
        start = 1'b1;
        s1 = cyc + 1;
        repeat (DIV + 10) @(negedge clk);
        checks++;
        if (dig !== model_digits((cyc - s1 - 2) / DIV)) begin
            errors++;
            $display("FAIL rst_prerun: dig=%h, want %h", dig, model_digits((cyc - s1 - 2) / DIV));
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({running, ovf, upd, dig} !== 19'd0) begin
            errors++;
            $display("FAIL rst_midrun: run=%b ovf=%b upd=%b dig=%h, want all 0",
                     running, ovf, upd, dig);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        fork
            test_start();
            test_overflow();
        join
        test_freeze();
        test_abort();
        test_over_held();
        test_rst_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
